// File: rtl/matrix_pe_mc_pkg.sv
// Shared types and width helpers for the multi-channel matrix PE.
// Optional build macro: MATRIX_PE_MC_SAT_EN (saturating accumulation).
package matrix_pe_mc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StOut  = 2'd2
    } mpe_state_e;

    // Full-precision width of a VEC_LEN-term signed dot product.
    function automatic int unsigned dot_w(input int unsigned data_w, input int unsigned vec_len);
        return 2 * data_w + $clog2(vec_len);
    endfunction

    // One guard bit above the wider addend so acc + dot never overflows.
    function automatic int unsigned sum_w(input int unsigned dw, input int unsigned acc_w);
        return ((dw > acc_w) ? dw : acc_w) + 1;
    endfunction

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] val,
                                                     input int unsigned       width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

endpackage

// File: rtl/matrix_pe_mc_if.sv
// Handshake bundle between ib_ctl, NRAM/WRAM read ports, the PE and writeback.
interface matrix_pe_mc_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned VEC_LEN = 64,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned ITER_W  = 8
);
    logic [VEC_LEN*DATA_W-1:0]        nram_mpe_neuron;
    logic                             nram_mpe_neuron_valid;
    logic                             nram_mpe_neuron_ready;
    logic [NUM_CH*VEC_LEN*DATA_W-1:0] wram_mpe_weight;
    logic                             wram_mpe_weight_valid;
    logic                             wram_mpe_weight_ready;
    logic [ITER_W-1:0]                ib_ctl_uop;
    logic                             ib_ctl_uop_valid;
    logic                             ib_ctl_uop_ready;
    logic [NUM_CH*ACC_W-1:0]          result;
    logic                             result_valid;
    logic                             result_ready;

    // Environment side: sources operands/uops, sinks results.
    modport master (
        output nram_mpe_neuron, nram_mpe_neuron_valid, wram_mpe_weight, wram_mpe_weight_valid,
        output ib_ctl_uop, ib_ctl_uop_valid, result_ready,
        input  nram_mpe_neuron_ready, wram_mpe_weight_ready, ib_ctl_uop_ready,
        input  result, result_valid
    );

    // PE side.
    modport slave (
        input  nram_mpe_neuron, nram_mpe_neuron_valid, wram_mpe_weight, wram_mpe_weight_valid,
        input  ib_ctl_uop, ib_ctl_uop_valid, result_ready,
        output nram_mpe_neuron_ready, wram_mpe_weight_ready, ib_ctl_uop_ready,
        output result, result_valid
    );
endinterface

// File: rtl/pe_dot_ch.sv
// One channel's combinational signed dot product over VEC_LEN elements.
module pe_dot_ch
    import matrix_pe_mc_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned VEC_LEN = 64,
    parameter int unsigned DOT_W   = dot_w(DATA_W, VEC_LEN)
) (
    input  logic [VEC_LEN*DATA_W-1:0] neuron,
    input  logic [VEC_LEN*DATA_W-1:0] weight,
    output logic signed [DOT_W-1:0]   dot
);

    // Sum of element-wise signed products at full precision.
    always_comb begin
        logic signed [DATA_W-1:0]   a;
        logic signed [DATA_W-1:0]   b;
        logic signed [2*DATA_W-1:0] prod;
        dot = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            a    = neuron[i*DATA_W +: DATA_W];
            b    = weight[i*DATA_W +: DATA_W];
            prod = a * b;
            dot  = dot + DOT_W'(prod);
        end
    end

endmodule

// File: rtl/matrix_pe_mc.sv
// Multi-channel matrix PE: accumulates NUM_CH dot products over a uop-given
// beat count and presents them through a valid/ready result handshake.
// Optional build macro: MATRIX_PE_MC_SAT_EN (clamp instead of wrap per beat).
module matrix_pe_mc
    import matrix_pe_mc_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned VEC_LEN = 64,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned ITER_W  = 8
) (
    input logic            clk,
    input logic            rst_n,
    matrix_pe_mc_if.slave  bus
);

    localparam int unsigned DOT_W = dot_w(DATA_W, VEC_LEN);
    localparam int unsigned SUM_W = sum_w(DOT_W, ACC_W);
    localparam int unsigned VEC_W = VEC_LEN * DATA_W;

    mpe_state_e              state_q, state_d;
    logic [ITER_W-1:0]       count_q, count_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic signed [ACC_W-1:0] acc_q   [NUM_CH];
    logic signed [ACC_W-1:0] acc_d   [NUM_CH];
    logic signed [ACC_W-1:0] acc_nxt [NUM_CH];
    logic signed [DOT_W-1:0] dot     [NUM_CH];

    logic uop_fire;
    logic beat;

    assign uop_fire = (state_q == StIdle) && bus.ib_ctl_uop_valid;
    assign beat     = (state_q == StRun) && bus.nram_mpe_neuron_valid
                      && bus.wram_mpe_weight_valid;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [SUM_W-1:0] sum;

        pe_dot_ch #(
            .DATA_W  (DATA_W),
            .VEC_LEN (VEC_LEN),
            .DOT_W   (DOT_W)
        ) u_dot (
            .neuron (bus.nram_mpe_neuron),
            .weight (bus.wram_mpe_weight[c*VEC_W +: VEC_W]),
            .dot    (dot[c])
        );

        assign sum = SUM_W'(acc_q[c]) + SUM_W'(dot[c]);

`ifdef MATRIX_PE_MC_SAT_EN
        logic signed [63:0] clamped;
        logic               unused_clamped_hi;
        assign clamped           = sat_clamp(64'(sum), ACC_W);
        assign acc_nxt[c]        = clamped[ACC_W-1:0];
        assign unused_clamped_hi = ^clamped[63:ACC_W];
`else
        // Two's-complement wrap: only the low ACC_W bits are kept.
        logic unused_sum_hi;
        assign acc_nxt[c]    = sum[ACC_W-1:0];
        assign unused_sum_hi = ^sum[SUM_W-1:ACC_W];
`endif
    end

    // State, counters and accumulators; reset aborts any run in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            iter_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            iter_q  <= iter_d;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        iter_d  = iter_q;
        for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_q[c];
        bus.ib_ctl_uop_ready      = 1'b0;
        bus.nram_mpe_neuron_ready = 1'b0;
        bus.wram_mpe_weight_ready = 1'b0;
        bus.result_valid          = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.ib_ctl_uop_ready = 1'b1;
                if (uop_fire) begin
                    count_d = bus.ib_ctl_uop;
                    iter_d  = '0;
                    for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Joint handshake: each side is ready only when the other is valid.
                bus.nram_mpe_neuron_ready = bus.wram_mpe_weight_valid;
                bus.wram_mpe_weight_ready = bus.nram_mpe_neuron_valid;
                if (beat) begin
                    iter_d = iter_q + ITER_W'(1);
                    for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_nxt[c];
                    // count 0 wraps to all-ones here, giving 2^ITER_W beats.
                    if (iter_q == count_q - ITER_W'(1)) state_d = StOut;
                end
            end
            StOut: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Results come straight from the accumulator registers.
    always_comb begin
        bus.result = '0;
        for (int c = 0; c < NUM_CH; c++) bus.result[c*ACC_W +: ACC_W] = acc_q[c];
    end

endmodule

// File: tb/tb_matrix_pe_mc.sv
// Directed bench for matrix_pe_mc (32-bit and 24-bit accumulator instances).
module tb_matrix_pe_mc;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned VEC_LEN = 64;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned ITER_W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_pe_mc_if #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .NUM_CH(NUM_CH), .ACC_W(32),
                      .ITER_W(ITER_W)) bus ();
    matrix_pe_mc_if #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .NUM_CH(NUM_CH), .ACC_W(24),
                      .ITER_W(ITER_W)) bus24 ();

    matrix_pe_mc #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .NUM_CH(NUM_CH), .ACC_W(32),
                   .ITER_W(ITER_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    matrix_pe_mc #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .NUM_CH(NUM_CH), .ACC_W(24),
                   .ITER_W(ITER_W)) u_dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus24)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ch32(input int c);
        return longint'($signed(bus.result[c*32 +: 32]));
    endfunction

    task automatic set_ops(input logic [7:0] n, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < VEC_LEN; i++) begin
            bus.nram_mpe_neuron[i*DATA_W +: DATA_W] = n;
            for (int c = 0; c < NUM_CH; c++)
                bus.wram_mpe_weight[(c*VEC_LEN+i)*DATA_W +: DATA_W] = w[c];
        end
    endtask

    task automatic send_uop(input logic [7:0] cnt);
        int n = 0;
        bus.ib_ctl_uop       = cnt;
        bus.ib_ctl_uop_valid = 1'b1;
        #1;
        while (!bus.ib_ctl_uop_ready && n < 20) begin
            tick();
            n++;
        end
        check("uop_ready_in_idle", longint'(bus.ib_ctl_uop_ready), 1);
        tick();
        bus.ib_ctl_uop_valid = 1'b0;
        check("uop_ready_low_in_run", longint'(bus.ib_ctl_uop_ready), 0);
    endtask

    task automatic set_valids(input logic v);
        bus.nram_mpe_neuron_valid = v;
        bus.wram_mpe_weight_valid = v;
        #1;
    endtask

    task automatic check_res(input string tag, input longint e0, input longint e1,
                             input longint e2, input longint e3);
        check($sformatf("%s_ch0", tag), ch32(0), e0);
        check($sformatf("%s_ch1", tag), ch32(1), e1);
        check($sformatf("%s_ch2", tag), ch32(2), e2);
        check($sformatf("%s_ch3", tag), ch32(3), e3);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_uop_ready"}, longint'(bus.ib_ctl_uop_ready), 1);
        check({tag, "_result_valid"}, longint'(bus.result_valid), 0);
        check({tag, "_result_nonzero"}, longint'(|bus.result), 0);
        check({tag, "_nram_ready"}, longint'(bus.nram_mpe_neuron_ready), 0);
        check({tag, "_wram_ready"}, longint'(bus.wram_mpe_weight_ready), 0);
    endtask

    task automatic finish_out(input string tag);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check({tag, "_idle_uop_ready"}, longint'(bus.ib_ctl_uop_ready), 1);
        check({tag, "_idle_result_valid"}, longint'(bus.result_valid), 0);
    endtask

    initial begin
        logic [127:0] held;
        int beats;
        int n;
        longint exp24;

        bus.nram_mpe_neuron = '0;   bus.nram_mpe_neuron_valid = 1'b0;
        bus.wram_mpe_weight = '0;   bus.wram_mpe_weight_valid = 1'b0;
        bus.ib_ctl_uop = '0;        bus.ib_ctl_uop_valid = 1'b0;
        bus.result_ready = 1'b0;
        bus24.nram_mpe_neuron = '0; bus24.nram_mpe_neuron_valid = 1'b0;
        bus24.wram_mpe_weight = '0; bus24.wram_mpe_weight_valid = 1'b0;
        bus24.ib_ctl_uop = '0;      bus24.ib_ctl_uop_valid = 1'b0;
        bus24.result_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Case 1: single beat, mixed channel weights
        set_ops(8'sd1, 8'sd2, -8'sd1, 8'sd0, 8'sd127);
        send_uop(8'd1);
        set_valids(1'b1);
        check("c1_nram_ready", longint'(bus.nram_mpe_neuron_ready), 1);
        check("c1_wram_ready", longint'(bus.wram_mpe_weight_ready), 1);
        check("c1_valid_before", longint'(bus.result_valid), 0);
        @(posedge clk); #1;
        check("c1_valid_after_beat", longint'(bus.result_valid), 1);
        check_res("c1", 128, -64, 0, 8128);

        // Case 3: backpressure holds the result; operands stay blocked
        held = bus.result;
        repeat (5) begin
            tick();
            check("c3_valid_held", longint'(bus.result_valid), 1);
            check("c3_result_stable", longint'(bus.result == held), 1);
            check("c3_uop_ready", longint'(bus.ib_ctl_uop_ready), 0);
            check("c3_nram_ready", longint'(bus.nram_mpe_neuron_ready), 0);
            check("c3_wram_ready", longint'(bus.wram_mpe_weight_ready), 0);
        end
        set_valids(1'b0);
        finish_out("c3");

        // Case 2: count 3 with gaps and one-sided valid cycles
        send_uop(8'd3);
        for (int k = 0; k < 3; k++) begin
            set_valids(1'b0);
            tick();
            bus.nram_mpe_neuron_valid = 1'b1;
            #1;
            check("c2_wram_ready_follows_nram", longint'(bus.wram_mpe_weight_ready), 1);
            check("c2_nram_ready_no_wvalid", longint'(bus.nram_mpe_neuron_ready), 0);
            tick();
            bus.wram_mpe_weight_valid = 1'b1;
            tick();
            if (k < 2) check("c2_valid_early", longint'(bus.result_valid), 0);
        end
        check("c2_valid_after_third", longint'(bus.result_valid), 1);
        check_res("c2", 384, -192, 0, 24384);
        repeat (2) begin
            tick();
            check("c2_no_extra_nram_ready", longint'(bus.nram_mpe_neuron_ready), 0);
            check("c2_no_extra_wram_ready", longint'(bus.wram_mpe_weight_ready), 0);
        end
        check_res("c2_hold", 384, -192, 0, 24384);
        set_valids(1'b0);
        finish_out("c2");

        // Case 4: count 0 means 256 beats
        set_ops(8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1);
        send_uop(8'd0);
        set_valids(1'b1);
        beats = 0;
        n = 0;
        while (!bus.result_valid && n < 400) begin
            if (bus.nram_mpe_neuron_ready && bus.wram_mpe_weight_ready) beats++;
            tick();
            n++;
        end
        set_valids(1'b0);
        check("c4_beats", beats, 256);
        check("c4_valid", longint'(bus.result_valid), 1);
        check_res("c4", 16384, 16384, 16384, 16384);
        finish_out("c4");

        // Case 5: 24-bit accumulators overflow on the ninth beat
        for (int i = 0; i < NUM_CH * VEC_LEN; i++) begin
            if (i < VEC_LEN) bus24.nram_mpe_neuron[i*DATA_W +: DATA_W] = 8'sd127;
            bus24.wram_mpe_weight[i*DATA_W +: DATA_W] = 8'sd127;
        end
        bus24.ib_ctl_uop       = 8'd9;
        bus24.ib_ctl_uop_valid = 1'b1;
        #1;
        check("c5_uop_ready", longint'(bus24.ib_ctl_uop_ready), 1);
        tick();
        bus24.ib_ctl_uop_valid      = 1'b0;
        bus24.nram_mpe_neuron_valid = 1'b1;
        bus24.wram_mpe_weight_valid = 1'b1;
        #1;
        beats = 0;
        n = 0;
        while (!bus24.result_valid && n < 40) begin
            if (bus24.nram_mpe_neuron_ready && bus24.wram_mpe_weight_ready) beats++;
            tick();
            n++;
        end
        bus24.nram_mpe_neuron_valid = 1'b0;
        bus24.wram_mpe_weight_valid = 1'b0;
        check("c5_beats", beats, 9);
`ifdef MATRIX_PE_MC_SAT_EN
        exp24 = 8388607;
`else
        exp24 = -7486912;
`endif
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("c5_ch%0d", c), longint'($signed(bus24.result[c*24 +: 24])), exp24);
        bus24.result_ready = 1'b1;
        tick();
        bus24.result_ready = 1'b0;
        check("c5_idle", longint'(bus24.ib_ctl_uop_ready), 1);

        // Case 6: asynchronous reset mid-run, then a clean case-1 run
        set_ops(8'sd1, 8'sd2, -8'sd1, 8'sd0, 8'sd127);
        send_uop(8'd4);
        set_valids(1'b1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("c6_async_rst");
        set_valids(1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        send_uop(8'd1);
        set_valids(1'b1);
        @(posedge clk); #1;
        set_valids(1'b0);
        check("c6_valid", longint'(bus.result_valid), 1);
        check_res("c6", 128, -64, 0, 8128);
        finish_out("c6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
